// File: rtl/sync_mode_sequencer.sv
// Sync-datapath configuration sequencer. It counts lines per field, classifies each field as
// NTSC/PAL and progressive/interlaced, debounces the shift switches, and commits config on field edges.
module sync_mode_sequencer #(
  parameter int LOCK_FIELDS     = 3,
  parameter int DEBOUNCE_CYCLES = 4096,
  parameter int LINE_MIN        = 200,
  parameter int LINE_MAX        = 330,
  parameter int NTSC_LINES_MAX  = 272,
  parameter int TIMEOUT_LINES   = 400
) (
  input  logic       clk12,
  input  logic       rst_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       interlace_in,
  input  logic [4:0] sw_240,
  input  logic [4:0] sw_480,
  output logic [4:0] shift_value,
  output logic       mode_prog,
  output logic       mode_pal,
  output logic       cfg_valid,
  output logic       cfg_update,
  output logic       led
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    COMMIT  = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  typedef struct packed {
    logic valid;
    logic pal;
    logic prog;
  } cand_t;

  localparam logic [9:0]  LINE_SAT  = 10'd1023;
  localparam logic [9:0]  LMIN      = 10'(LINE_MIN);
  localparam logic [9:0]  LMAX      = 10'(LINE_MAX);
  localparam logic [9:0]  NTSC_MAX  = 10'(NTSC_LINES_MAX);
  localparam logic [9:0]  TMO_LINES = 10'(TIMEOUT_LINES);
  localparam logic [3:0]  LOCK_N    = 4'(LOCK_FIELDS);
  localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [5:0]  LED_LAST  = 6'd59;

  // Edge detection and line counting
  logic       hs_q;
  logic       vs_q;
  logic       le;
  logic       fe;
  logic [9:0] line_cnt;
  logic [9:0] lines_end;
  cand_t      cand;

  assign le = hs_q & ~hsync_in;
  assign fe = vs_q & ~vsync_in;

  // A line edge coincident with the field edge belongs to the field that is ending.
  assign lines_end = (le && line_cnt != LINE_SAT) ? line_cnt + 10'd1 : line_cnt;

  always_comb begin
    cand       = '0;
    cand.valid = (lines_end >= LMIN) && (lines_end <= LMAX);
    cand.pal   = (lines_end > NTSC_MAX);
    cand.prog  = interlace_in;
  end

  always_ff @(negedge clk12 or negedge rst_n) begin
    if (!rst_n) begin
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      line_cnt <= '0;
    end else begin
      hs_q <= hsync_in;
      vs_q <= vsync_in;
      if (fe) begin
        line_cnt <= '0;
      end else if (le && line_cnt != LINE_SAT) begin
        line_cnt <= line_cnt + 10'd1;
      end
    end
  end

  // Switch debounce; index 0 is the 240p bank, index 1 the 480i bank
  logic [4:0]  raw_n    [2];
  logic [4:0]  raw_q    [2];
  logic [15:0] stab_cnt [2];
  logic [4:0]  deb      [2];

  always_comb begin
    raw_n[0] = ~sw_240;
    raw_n[1] = ~sw_480;
  end

  always_ff @(negedge clk12 or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        raw_q[b]    <= '0;
        stab_cnt[b] <= '0;
        deb[b]      <= '0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        raw_q[b] <= raw_n[b];
        if (raw_n[b] != raw_q[b]) begin
          stab_cnt[b] <= '0;
        end else if (stab_cnt[b] != DEB_LAST) begin
          stab_cnt[b] <= stab_cnt[b] + 16'd1;
        end
        if (stab_cnt[b] == DEB_LAST) begin
          deb[b] <= raw_q[b];
        end
      end
    end
  end

  // Mode FSM
  state_t     state;
  state_t     state_n;
  cand_t      stored;
  cand_t      stored_n;
  logic [3:0] match_cnt;
  logic [3:0] match_n;
  logic       timeout;
  logic       do_commit;
  logic       do_reload;
  logic [4:0] sel_bank;

  assign timeout  = (line_cnt >= TMO_LINES);
  assign sel_bank = stored.prog ? deb[0] : deb[1];

  always_comb begin
    state_n   = state;
    stored_n  = stored;
    match_n   = match_cnt;
    do_commit = 1'b0;
    do_reload = 1'b0;
    unique case (state)
      SEARCH: begin
        if (fe && cand.valid) begin
          state_n  = CONFIRM;
          stored_n = cand;
          match_n  = 4'd1;
        end
      end
      CONFIRM: begin
        if (timeout) begin
          state_n = SEARCH;
        end else if (fe) begin
          if (!cand.valid) begin
            state_n = SEARCH;
          end else if (cand != stored) begin
            stored_n = cand;
            match_n  = 4'd1;
          end else begin
            match_n = match_cnt + 4'd1;
            if (match_n == LOCK_N) state_n = COMMIT;
          end
        end
      end
      COMMIT: begin
        do_commit = 1'b1;
        state_n   = LOCKED;
      end
      LOCKED: begin
        if (timeout) begin
          state_n = SEARCH;
        end else if (fe) begin
          if (!cand.valid) begin
            state_n = SEARCH;
          end else if (cand != stored) begin
            state_n  = CONFIRM;
            stored_n = cand;
            match_n  = 4'd1;
          end else if (sel_bank != shift_value) begin
            do_reload = 1'b1;
          end
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  always_ff @(negedge clk12 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      stored    <= '0;
      match_cnt <= '0;
    end else begin
      state     <= state_n;
      stored    <= stored_n;
      match_cnt <= match_n;
    end
  end

  // cfg_valid marks the committed outputs as trustworthy; cfg_update pulses once in the
  // cycle a new shift_value/mode first appears. Outputs hold their values outside LOCKED.
  logic [5:0] led_cnt;

  always_ff @(negedge clk12 or negedge rst_n) begin
    if (!rst_n) begin
      shift_value <= '0;
      mode_prog   <= 1'b0;
      mode_pal    <= 1'b0;
      cfg_valid   <= 1'b0;
      cfg_update  <= 1'b0;
      led         <= 1'b0;
      led_cnt     <= '0;
    end else begin
      cfg_update <= do_commit | do_reload;
      cfg_valid  <= (state_n == LOCKED);
      if (do_commit) begin
        mode_prog   <= stored.prog;
        mode_pal    <= stored.pal;
        shift_value <= sel_bank;
      end else if (do_reload) begin
        shift_value <= sel_bank;
      end
      if (state != LOCKED || state_n != LOCKED) begin
        led_cnt <= '0;
        led     <= 1'b0;
      end else if (fe) begin
        if (led_cnt == LED_LAST) begin
          led_cnt <= '0;
          led     <= ~led;
        end else begin
          led_cnt <= led_cnt + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_mode_sequencer.sv
// Field-level bench for sync_mode_sequencer: directed scenarios plus randomized fields,
// checked against a field-by-field behavioural model of the lock/commit rules.
module tb_sync_mode_sequencer;

  localparam int DEB  = 200;
  localparam int LOCK = 3;

  logic       clk12        = 1'b0;
  logic       rst_n        = 1'b1;
  logic       hsync_in     = 1'b1;
  logic       vsync_in     = 1'b1;
  logic       interlace_in = 1'b1;
  logic [4:0] sw_240       = 5'h1f;
  logic [4:0] sw_480       = 5'h1f;
  logic [4:0] shift_value;
  logic       mode_prog;
  logic       mode_pal;
  logic       cfg_valid;
  logic       cfg_update;
  logic       led;

  sync_mode_sequencer #(
    .LOCK_FIELDS    (LOCK),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk12       (clk12),
    .rst_n       (rst_n),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .interlace_in(interlace_in),
    .sw_240      (sw_240),
    .sw_480      (sw_480),
    .shift_value (shift_value),
    .mode_prog   (mode_prog),
    .mode_pal    (mode_pal),
    .cfg_valid   (cfg_valid),
    .cfg_update  (cfg_update),
    .led         (led)
  );

  // Clock / cycle counter / update monitor
  always #5 clk12 = ~clk12;

  int cyc = 0;
  always @(negedge clk12) cyc <= cyc + 1;

  int upd_cnt      = 0;
  int last_upd_cyc = -1;
  always @(posedge clk12) begin
    if (cfg_update === 1'b1) begin
      upd_cnt      <= upd_cnt + 1;
      last_upd_cyc <= cyc;
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference model state (field granularity)
  logic       m_locked;
  logic [2:0] m_last;
  int         m_run;
  logic [4:0] m_shift;
  logic       m_prog;
  logic       m_pal;
  logic       m_led;
  int         m_led_cnt;
  logic [4:0] cur240, cur480;
  logic [4:0] deb240, deb480;
  int         chg240, chg480;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("cfg_valid", {31'd0, cfg_valid}, {31'd0, m_locked});
    chk("shift_value", {27'd0, shift_value}, {27'd0, m_shift});
    chk("mode_prog", {31'd0, mode_prog}, {31'd0, m_prog});
    chk("mode_pal", {31'd0, mode_pal}, {31'd0, m_pal});
    chk("led", {31'd0, led}, {31'd0, m_led});
  endtask

  // A bank's debounced value becomes its raw value once held for DEB cycles.
  task automatic apply_sw(input logic [4:0] n240, input logic [4:0] n480);
    if (n240 != cur240) begin
      if (cyc - chg240 >= DEB) deb240 = cur240;
      cur240 = n240;
      chg240 = cyc;
    end
    if (n480 != cur480) begin
      if (cyc - chg480 >= DEB) deb480 = cur480;
      cur480 = n480;
      chg480 = cyc;
    end
    sw_240 = ~cur240;
    sw_480 = ~cur480;
  endtask

  task automatic leave_lock();
    m_locked  = 1'b0;
    m_led     = 1'b0;
    m_led_cnt = 0;
  endtask

  task automatic model_fe(input int lines, input logic prog, output int exp_upd, output int exp_lat);
    logic       valid;
    logic       pal;
    logic [2:0] cand;
    logic [4:0] bank;
    if (cyc - chg240 >= DEB) deb240 = cur240;
    if (cyc - chg480 >= DEB) deb480 = cur480;
    valid   = (lines >= 200) && (lines <= 330);
    pal     = (lines > 272);
    cand    = {valid, pal, prog};
    bank    = prog ? deb240 : deb480;
    exp_upd = 0;
    exp_lat = 0;
    if (!valid) begin
      m_run = 0;
      leave_lock();
    end else if (m_locked) begin
      if (cand == m_last) begin
        if (bank != m_shift) begin
          m_shift = bank;
          exp_upd = 1;
          exp_lat = 1;
        end
        m_led_cnt++;
        if (m_led_cnt == 60) begin
          m_led_cnt = 0;
          m_led     = ~m_led;
        end
      end else begin
        leave_lock();
        m_last = cand;
        m_run  = 1;
      end
    end else if (m_run > 0 && cand == m_last) begin
      m_run++;
      if (m_run == LOCK) begin
        m_locked  = 1'b1;
        m_prog    = prog;
        m_pal     = pal;
        m_shift   = bank;
        m_led     = 1'b0;
        m_led_cnt = 0;
        exp_upd   = 1;
        exp_lat   = 2;
      end
    end else begin
      m_last = cand;
      m_run  = 1;
    end
  endtask

  // Driver tasks
  task automatic do_reset();
    @(posedge clk12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_shift", {27'd0, shift_value}, 32'd0);
    chk("rst_prog", {31'd0, mode_prog}, 32'd0);
    chk("rst_pal", {31'd0, mode_pal}, 32'd0);
    chk("rst_valid", {31'd0, cfg_valid}, 32'd0);
    chk("rst_update", {31'd0, cfg_update}, 32'd0);
    chk("rst_led", {31'd0, led}, 32'd0);
    repeat (3) @(posedge clk12);
    rst_n     = 1'b1;
    m_locked  = 1'b0;
    m_last    = 3'd0;
    m_run     = 0;
    m_shift   = 5'd0;
    m_prog    = 1'b0;
    m_pal     = 1'b0;
    m_led     = 1'b0;
    m_led_cnt = 0;
    deb240    = 5'd0;
    deb480    = 5'd0;
    chg240    = cyc;
    chg480    = cyc;
  endtask

  task automatic drive_line();
    @(posedge clk12);
    hsync_in = 1'b0;
    @(posedge clk12);
    hsync_in = 1'b1;
  endtask

  // swm: 1 = new random banks early, 2 = late bounce on sw_240[0], 3 = mid-field bounce then hold
  task automatic sw_action(input int swm, input int i, input int n_sep);
    if (swm == 1 && i == 2)
      apply_sw(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    if (swm == 2 && i >= n_sep - 5)
      apply_sw(cur240 ^ 5'd1, cur480);
    if (swm == 3 && i <= 120 && (i % 3) == 0)
      apply_sw(cur240 ^ 5'd1, cur480);
  endtask

  task automatic end_field(input int lines, input logic prog, input bit coinc, input int base);
    int e;
    int exp_upd;
    int exp_lat;
    @(posedge clk12);
    vsync_in = 1'b0;
    if (coinc) hsync_in = 1'b0;
    e = cyc;
    model_fe(lines, prog, exp_upd, exp_lat);
    @(posedge clk12);
    vsync_in = 1'b1;
    hsync_in = 1'b1;
    repeat (3) @(posedge clk12);
    check_outputs();
    chk("upd_count", upd_cnt - base, exp_upd);
    if (exp_upd != 0) chk("upd_latency", last_upd_cyc - e, exp_lat);
  endtask

  task automatic run_field(input int lines, input logic prog, input bit coinc, input int swm);
    int n_sep;
    int base;
    base         = upd_cnt;
    interlace_in = prog;
    n_sep        = coinc ? lines - 1 : lines;
    for (int i = 0; i < n_sep; i++) begin
      sw_action(swm, i, n_sep);
      drive_line();
    end
    end_field(lines, prog, coinc, base);
  endtask

  // hsync keeps running with no vsync: lock must drop once 400 lines accumulate.
  task automatic lost_signal(input logic prog);
    int base;
    base         = upd_cnt;
    interlace_in = prog;
    for (int i = 0; i < 410; i++) begin
      drive_line();
      if (i == 399) chk("lost_pre_valid", {31'd0, cfg_valid}, {31'd0, m_locked});
      if (i == 400) begin
        m_run = 0;
        leave_lock();
        chk("lost_valid", {31'd0, cfg_valid}, 32'd0);
      end
    end
    check_outputs();
    chk("lost_upd", upd_cnt - base, 0);
    end_field(410, prog, 1'b0, base);
  endtask

  // Directed sequence, then randomized fields
  initial begin
    int   lines;
    logic prog;
    cur240 = 5'b00011;
    cur480 = 5'b00101;
    sw_240 = ~cur240;
    sw_480 = ~cur480;
    chg240 = 0;
    chg480 = 0;
    do_reset();

    // NTSC progressive lock with sw_240 = 5'b11100
    repeat (3) run_field(262, 1'b1, 1'b0, 0);
    chk("t1_shift", {27'd0, shift_value}, 32'd3);
    chk("t1_valid", {31'd0, cfg_valid}, 32'd1);

    // Move to PAL line count
    run_field(312, 1'b1, 1'b0, 0);
    chk("t2_drop", {31'd0, cfg_valid}, 32'd0);
    run_field(312, 1'b1, 1'b0, 0);
    run_field(312, 1'b1, 1'b0, 0);
    chk("t2_pal", {31'd0, mode_pal}, 32'd1);

    // Switch bounce: late change waits one field, settled bounce is taken at the FE
    run_field(312, 1'b1, 1'b0, 2);
    run_field(312, 1'b1, 1'b0, 0);
    run_field(312, 1'b1, 1'b0, 3);
    run_field(312, 1'b0, 1'b0, 1);
    run_field(312, 1'b0, 1'b0, 0);
    run_field(312, 1'b0, 1'b0, 0);

    // Signal loss
    lost_signal(1'b0);

    // Short field breaks confirmation
    run_field(262, 1'b1, 1'b1, 0);
    run_field(150, 1'b1, 1'b0, 0);
    run_field(262, 1'b1, 1'b0, 0);
    run_field(262, 1'b1, 1'b0, 0);
    run_field(262, 1'b1, 1'b1, 0);

    // Line-count boundaries
    run_field(199, 1'b1, 1'b0, 0);
    run_field(200, 1'b1, 1'b0, 0);
    run_field(200, 1'b1, 1'b1, 0);
    run_field(331, 1'b1, 1'b0, 0);
    repeat (3) run_field(330, 1'b1, 1'b0, 0);
    repeat (3) run_field(272, 1'b1, 1'b1, 0);
    run_field(273, 1'b1, 1'b0, 0);

    // Reset while confirming, then coincident LE+FE fields (261+1 lines)
    do_reset();
    repeat (3) run_field(262, 1'b1, 1'b1, 0);
    chk("t6_pal", {31'd0, mode_pal}, 32'd0);
    chk("t6_valid", {31'd0, cfg_valid}, 32'd1);

    // Heartbeat: 3 fields to lock, 60 locked fields toggle led, 2 more hold it
    repeat (65) run_field(200, 1'b0, 1'b0, 0);
    chk("led_on", {31'd0, led}, 32'd1);

    // Randomized fields with sticky line counts so locks occur
    lines = 262;
    prog  = 1'b1;
    for (int f = 0; f < 30; f++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 10) lines = int'($urandom_range(150, 350));
      else if (r < 20) lines = 262;
      else if (r < 28) lines = 312;
      if ($urandom_range(0, 15) == 0) prog = ~prog;
      run_field(lines, prog, ($urandom_range(0, 1) == 1), int'($urandom_range(0, 4)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
